// File: rtl/dmm_bridge_pkg.sv
// Purpose : shared load/store type codes, bus size codes and FSM encoding for the data-memory bridge.
// Latency : n/a (declarations and pure functions only).
// Backpressure: n/a.
package dmm_bridge_pkg;

    localparam logic [2:0] LSTYPE_LB  = 3'd0;
    localparam logic [2:0] LSTYPE_LBU = 3'd1;
    localparam logic [2:0] LSTYPE_LH  = 3'd2;
    localparam logic [2:0] LSTYPE_LHU = 3'd3;
    localparam logic [2:0] LSTYPE_LW  = 3'd4;
    localparam logic [2:0] LSTYPE_SB  = 3'd5;
    localparam logic [2:0] LSTYPE_SH  = 3'd6;
    localparam logic [2:0] LSTYPE_SW  = 3'd7;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmm_state_e;

    // Bus transfer size for a load/store type.
    function automatic logic [1:0] lstype_size(input logic [2:0] t);
        logic [1:0] s;
        case (t)
            LSTYPE_LB, LSTYPE_LBU, LSTYPE_SB: s = SIZE_BYTE;
            LSTYPE_LH, LSTYPE_LHU, LSTYPE_SH: s = SIZE_HALF;
            default:                          s = SIZE_WORD;
        endcase
        return s;
    endfunction

    // Replicate low-aligned store data across all byte lanes so the slave
    // can pick whichever lane the address selects.
    function automatic logic [31:0] store_lanes(input logic [2:0] t, input logic [31:0] wdata);
        logic [31:0] v;
        case (t)
            LSTYPE_SB: v = {4{wdata[7:0]}};
            LSTYPE_SH: v = {2{wdata[15:0]}};
            default:   v = wdata;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dmm_bridge_if.sv
// Purpose : MEM-stage request/result bundle and SRAM-like data bus bundle for the bridge.
// Latency : n/a (wiring only).
// Backpressure: MEM side sees ready/complete; bus side uses req/addr_ok/data_ok.
// Ports   : dmm_mem_if  master = MEM stage, slave = bridge.
//           dmm_bus_if  master = bridge,    slave = cache / AXI bridge.
interface dmm_mem_if #(parameter int ADDR_WIDTH = 32);
    logic                  mem_valid;
    logic                  mem_wren;
    logic [2:0]            mem_lw_sw_type;
    logic [ADDR_WIDTH-1:0] mem_dmm_addr;
    logic [31:0]           mem_dmm_wdata;
    logic                  mem_cancel;
    logic                  stage_advance;
    logic                  ready;
    logic                  complete;
    logic [31:0]           dmm_load_val;

    modport master (
        output mem_valid, mem_wren, mem_lw_sw_type, mem_dmm_addr, mem_dmm_wdata,
               mem_cancel, stage_advance,
        input  ready, complete, dmm_load_val
    );
    modport slave (
        input  mem_valid, mem_wren, mem_lw_sw_type, mem_dmm_addr, mem_dmm_wdata,
               mem_cancel, stage_advance,
        output ready, complete, dmm_load_val
    );
endinterface

interface dmm_bus_if #(parameter int ADDR_WIDTH = 32);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [31:0]           data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [31:0]           data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );
    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmm_bridge_load_ext.sv
// Purpose : select the addressed byte/half of a raw read word and sign/zero extend it.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_type (load/store type), i_addr_lo (addr[1:0]), i_rdata (raw word), o_val (extended value; 0 for stores).
module dmm_load_ext
    import dmm_bridge_pkg::*;
(
    input  logic [2:0]  i_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_val
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_val = 32'd0;
        case (i_type)
            LSTYPE_LB:  o_val = {{24{w_byte[7]}}, w_byte};
            LSTYPE_LBU: o_val = {24'd0, w_byte};
            LSTYPE_LH:  o_val = {{16{w_half[15]}}, w_half};
            LSTYPE_LHU: o_val = {16'd0, w_half};
            LSTYPE_LW:  o_val = i_rdata;
            default:    o_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmm_bridge.sv
// Purpose : MEM-stage data-memory access controller driving an SRAM-like req/addr_ok/data_ok bus.
// Latency : issue -> complete in 2 cycles minimum (addr_ok at issue, data_ok next cycle).
// Backpressure: ready drops while a request waits for addr_ok; result held in DONE until stage_advance.
// Ports   : clk, reset (async, active high); mem (dmm_mem_if.slave); bus (dmm_bus_if.master).
module dmm_bridge
    import dmm_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    dmm_mem_if.slave   mem,
    dmm_bus_if.master  bus
);

    dmm_state_e            r_state;
    dmm_state_e            w_state_nxt;
    logic [31:0]           r_rdata;
    logic [2:0]            r_type;
    logic [1:0]            r_addr_lo;
    logic                  w_issue;
    logic                  w_capture;
    logic [31:0]           w_ext_val;
    logic [ADDR_WIDTH-1:0] w_addr;

    // The MEM stage holds its request fields stable until advance, so the
    // bus fields are driven straight from them.
    assign w_addr         = mem.mem_dmm_addr;
    assign bus.data_addr  = w_addr;
    assign bus.data_wr    = mem.mem_wren;
    assign bus.data_size  = lstype_size(mem.mem_lw_sw_type);
    assign bus.data_wdata = store_lanes(mem.mem_lw_sw_type, mem.mem_dmm_wdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        bus.data_req = 1'b0;
        mem.complete = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_issue      = mem.mem_valid && !mem.mem_cancel;
                bus.data_req = w_issue;
                // Nothing to access (no request or flushed): report done at once.
                mem.complete = !w_issue;
                if (w_issue) begin
                    w_state_nxt = bus.data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                // Once raised, req stays up regardless of a late flush.
                bus.data_req = 1'b1;
                if (bus.data_addr_ok) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.data_data_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                mem.complete = 1'b1;
                if (mem.stage_advance) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Hold the bus quiet while reset is applied, even if the stage still
        // presents a request.
        if (reset) begin
            bus.data_req = 1'b0;
            mem.complete = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata   <= 32'd0;
            r_type    <= 3'd0;
            r_addr_lo <= 2'd0;
        end else if (w_capture) begin
            if (!mem.mem_wren) begin
                r_rdata <= bus.data_rdata;
            end
            r_type    <= mem.mem_lw_sw_type;
            r_addr_lo <= w_addr[1:0];
        end
    end

    dmm_load_ext u_load_ext (
        .i_type    (r_type),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (r_rdata),
        .o_val     (w_ext_val)
    );

    assign mem.ready        = (r_state != ST_REQ);
    assign mem.dmm_load_val = (r_state == ST_DONE) ? w_ext_val : 32'd0;

endmodule

// File: tb/tb_dmm_bridge.sv
module tb_dmm_bridge;

    typedef struct {
        logic [2:0]  ty;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ao;      // cycles addr_ok is withheld after issue
        int          dl;      // cycles data_ok is withheld in WAIT
        int          hold;    // cycles stage_advance is withheld in DONE
        logic [31:0] exp_val;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_size;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmm_mem_if #(.ADDR_WIDTH(32)) mem_if ();
    dmm_bus_if #(.ADDR_WIDTH(32)) bus_if ();

    dmm_bridge #(.ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mem   (mem_if),
        .bus   (bus_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (arithmetic on the rules) ----------------
    function automatic logic [1:0] model_size(input logic [2:0] ty);
        if (ty == 0 || ty == 1 || ty == 5) return 2'd0;
        if (ty == 2 || ty == 3 || ty == 6) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] ty, input logic [31:0] wd);
        if (ty == 5) return (wd & 32'hFF) * 32'h0101_0101;
        if (ty == 6) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] ty, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] w;
        int          off;
        off = int'(addr % 4);
        w   = 32'd0;
        if (ty == 0 || ty == 1) begin
            w = (rd >> (8 * off)) & 32'hFF;
            if (ty == 0 && w >= 128) w = w - 32'd256;
        end else if (ty == 2 || ty == 3) begin
            w = (rd >> (8 * off)) & 32'hFFFF;
            if (ty == 2 && w >= 32768) w = w - 32'd65536;
        end else if (ty == 4) begin
            w = rd;
        end
        return w;
    endfunction

    task automatic idle_inputs();
        mem_if.mem_valid      = 1'b0;
        mem_if.mem_wren       = 1'b0;
        mem_if.mem_lw_sw_type = 3'd0;
        mem_if.mem_dmm_addr   = 32'd0;
        mem_if.mem_dmm_wdata  = 32'd0;
        mem_if.mem_cancel     = 1'b0;
        mem_if.stage_advance  = 1'b0;
        bus_if.data_addr_ok   = 1'b0;
        bus_if.data_data_ok   = 1'b0;
        bus_if.data_rdata     = 32'd0;
    endtask

    // One full transaction; begins in IDLE just after a rising edge, ends
    // just after the edge that consumes stage_advance (back in IDLE).
    task automatic run_txn(input string tag, input vec_t v);
        int   reqs;
        logic wr;
        reqs = 0;
        wr   = (v.ty >= 3'd5);
        mem_if.mem_valid      = 1'b1;
        mem_if.mem_wren       = wr;
        mem_if.mem_lw_sw_type = v.ty;
        mem_if.mem_dmm_addr   = v.addr;
        mem_if.mem_dmm_wdata  = v.wdata;
        mem_if.mem_cancel     = 1'b0;
        mem_if.stage_advance  = 1'b0;
        bus_if.data_addr_ok   = (v.ao == 0);
        bus_if.data_data_ok   = 1'b0;
        bus_if.data_rdata     = v.rdata;
        #1;
        check({tag, " issue_req"}, 32'(bus_if.data_req), 32'd1);
        check({tag, " issue_size"}, 32'(bus_if.data_size), 32'(v.exp_size));
        check({tag, " issue_wr"}, 32'(bus_if.data_wr), 32'(wr));
        check({tag, " issue_addr"}, bus_if.data_addr, v.addr);
        if (wr) check({tag, " issue_wdata"}, bus_if.data_wdata, v.exp_wdata);
        check({tag, " issue_ready"}, 32'(mem_if.ready), 32'd1);
        check({tag, " issue_complete"}, 32'(mem_if.complete), 32'd0);
        if (bus_if.data_req) reqs++;
        @(posedge clk); #1;
        for (int k = 1; k <= v.ao; k++) begin
            bus_if.data_addr_ok = (k == v.ao);
            #1;
            check({tag, " req_ready"}, 32'(mem_if.ready), 32'd0);
            check({tag, " req_complete"}, 32'(mem_if.complete), 32'd0);
            if (wr) check({tag, " req_wdata"}, bus_if.data_wdata, v.exp_wdata);
            if (bus_if.data_req) reqs++;
            @(posedge clk); #1;
        end
        check({tag, " req_cycles"}, 32'(reqs), 32'(v.ao + 1));
        bus_if.data_addr_ok = 1'b0;
        for (int k = 0; k <= v.dl; k++) begin
            bus_if.data_data_ok = (k == v.dl);
            #1;
            check({tag, " wait_req"}, 32'(bus_if.data_req), 32'd0);
            check({tag, " wait_complete"}, 32'(mem_if.complete), 32'd0);
            check({tag, " wait_val"}, mem_if.dmm_load_val, 32'd0);
            @(posedge clk); #1;
        end
        // Stale bus data after capture must not leak into the result.
        bus_if.data_data_ok = 1'b0;
        bus_if.data_rdata   = $urandom;
        for (int k = 0; k <= v.hold; k++) begin
            mem_if.stage_advance = (k == v.hold);
            #1;
            check({tag, " done_complete"}, 32'(mem_if.complete), 32'd1);
            check({tag, " done_ready"}, 32'(mem_if.ready), 32'd1);
            check({tag, " done_val"}, mem_if.dmm_load_val, v.exp_val);
            @(posedge clk); #1;
        end
        mem_if.stage_advance = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        vec_t rv;
        logic [31:0] a;

        //         ty    addr          wdata         rdata         ao dl hold exp_val       exp_wdata     size
        vecs[0]  = '{3'd4, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 32'h0000_0000, 2'd2};
        vecs[1]  = '{3'd0, 32'h0000_1003, 32'h0000_0000, 32'h8012_3456, 0, 0, 0, 32'hFFFF_FF80, 32'h0000_0000, 2'd0};
        vecs[2]  = '{3'd1, 32'h0000_1003, 32'h0000_0000, 32'h8012_3456, 0, 1, 0, 32'h0000_0080, 32'h0000_0000, 2'd0};
        vecs[3]  = '{3'd6, 32'h0000_2002, 32'h0000_ABCD, 32'h0000_0000, 3, 0, 0, 32'h0000_0000, 32'hABCD_ABCD, 2'd1};
        vecs[4]  = '{3'd4, 32'h0000_1004, 32'h0000_0000, 32'h1234_5678, 1, 2, 5, 32'h1234_5678, 32'h0000_0000, 2'd2};
        vecs[5]  = '{3'd3, 32'h0000_3002, 32'h0000_0000, 32'h9ABC_1234, 0, 0, 0, 32'h0000_9ABC, 32'h0000_0000, 2'd1};
        vecs[6]  = '{3'd2, 32'h0000_3000, 32'h0000_0000, 32'h0000_8001, 0, 0, 0, 32'hFFFF_8001, 32'h0000_0000, 2'd1};
        vecs[7]  = '{3'd5, 32'h0000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 2, 1, 1, 32'h0000_0000, 32'hA5A5_A5A5, 2'd0};
        vecs[8]  = '{3'd7, 32'h0000_0008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, 3, 0, 32'h0000_0000, 32'hCAFE_F00D, 2'd2};
        vecs[9]  = '{3'd0, 32'h0000_0002, 32'h0000_0000, 32'h0045_0000, 0, 0, 0, 32'h0000_0045, 32'h0000_0000, 2'd0};
        vecs[10] = '{3'd2, 32'h0000_0002, 32'h0000_0000, 32'h8001_7FFF, 1, 0, 2, 32'hFFFF_8001, 32'h0000_0000, 2'd1};

        // ---------------- reset state ----------------
        idle_inputs();
        reset = 1'b1;
        #1;
        check("rst_req", 32'(bus_if.data_req), 32'd0);
        check("rst_complete", 32'(mem_if.complete), 32'd1);
        check("rst_ready", 32'(mem_if.ready), 32'd1);
        check("rst_val", mem_if.dmm_load_val, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- directed table (back-to-back) ----------------
        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);
        idle_inputs();

        // ---------------- cancelled request never issues ----------------
        mem_if.mem_valid      = 1'b1;
        mem_if.mem_cancel     = 1'b1;
        mem_if.mem_lw_sw_type = 3'd4;
        mem_if.mem_dmm_addr   = 32'h0000_4000;
        bus_if.data_addr_ok   = 1'b1;
        #1;
        check("cancel_req", 32'(bus_if.data_req), 32'd0);
        check("cancel_complete", 32'(mem_if.complete), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("cancel_req_hold", 32'(bus_if.data_req), 32'd0);
            check("cancel_complete_hold", 32'(mem_if.complete), 32'd1);
            check("cancel_ready_hold", 32'(mem_if.ready), 32'd1);
        end
        idle_inputs();
        @(posedge clk); #1;

        // ---------------- reset while in WAIT ----------------
        mem_if.mem_valid      = 1'b1;
        mem_if.mem_lw_sw_type = 3'd4;
        mem_if.mem_dmm_addr   = 32'h0000_5000;
        bus_if.data_addr_ok   = 1'b1;
        @(posedge clk); #1;
        bus_if.data_addr_ok = 1'b0;
        #1;
        check("wait_before_rst_complete", 32'(mem_if.complete), 32'd0);
        check("wait_before_rst_req", 32'(bus_if.data_req), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("midrst_req", 32'(bus_if.data_req), 32'd0);
        check("midrst_complete", 32'(mem_if.complete), 32'd1);
        check("midrst_ready", 32'(mem_if.ready), 32'd1);
        check("midrst_val", mem_if.dmm_load_val, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_if.mem_valid    = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("stray_ok_complete", 32'(mem_if.complete), 32'd1);
            check("stray_ok_val", mem_if.dmm_load_val, 32'd0);
            check("stray_ok_req", 32'(bus_if.data_req), 32'd0);
        end
        bus_if.data_data_ok = 1'b0;
        run_txn("post_rst", vecs[5]);

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 40; n++) begin
            rv.ty    = 3'($urandom_range(0, 7));
            a        = $urandom;
            if (model_size(rv.ty) == 2'd2) a = a & 32'hFFFF_FFFC;
            else if (model_size(rv.ty) == 2'd1) a = a & 32'hFFFF_FFFE;
            rv.addr      = a;
            rv.wdata     = $urandom;
            rv.rdata     = $urandom;
            rv.ao        = int'($urandom_range(0, 3));
            rv.dl        = int'($urandom_range(0, 3));
            rv.hold      = int'($urandom_range(0, 2));
            rv.exp_val   = model_load(rv.ty, rv.addr, rv.rdata);
            rv.exp_wdata = model_wdata(rv.ty, rv.wdata);
            rv.exp_size  = model_size(rv.ty);
            run_txn($sformatf("rnd%0d", n), rv);
        end
        idle_inputs();
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmm_bridge.md
Name: dmm_bridge

Overview:
- Data-memory access controller serving the MEM stage. Accepts the stage's load/store request and drives an SRAM-like data bus (req/addr_ok/data_ok).
- Holds the result and returns the extended load value, plus ready/complete, to the MEM stage. The MEM stage advances only on ready && complete.
- Sits between the MEM stage pipeline register and the data cache/AXI bridge.

Parameters:
- ADDR_WIDTH, 32, byte address width of mem_dmm_addr and data_addr.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  MEM stage holds a load/store
- mem_wren  in  1  1 = store, 0 = load
- mem_lw_sw_type  in  3  0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw
- mem_dmm_addr  in  ADDR_WIDTH  byte address
- mem_dmm_wdata  in  32  store data, low-aligned
- mem_cancel  in  1  exception/interrupt flush for this instruction; suppresses issue
- stage_advance  in  1  MEM stage consumed result this cycle
- ready  out  1  bus not back-pressuring: state != REQ
- complete  out  1  access result available, or no access required
- dmm_load_val  out  32  extended load data
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  ADDR_WIDTH  bus address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  raw read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Async reset forces:
  - state = IDLE
  - captured rdata = 0
  - latched type/addr[1:0] = 0
  - outputs: data_req=0, complete=1, ready=1, dmm_load_val=0
- issue = IDLE && mem_valid && !mem_cancel.
- data_req = issue || state==REQ. It is combinational and, once raised, is held until data_addr_ok.
- data_wr, data_size, data_addr, data_wdata are driven from the mem_* inputs in IDLE/REQ. The MEM stage holds its inputs stable until advance.
- Transitions:
  - IDLE: if issue && addr_ok -> WAIT; if issue && !addr_ok -> REQ; otherwise stay.
  - REQ: if addr_ok -> WAIT; otherwise stay. mem_cancel is ignored once requested.
  - WAIT: if data_ok -> DONE, capturing data_rdata (loads) and latching type and addr[1:0]. Otherwise stay.
  - DONE: if stage_advance -> IDLE; otherwise hold.
- data_ok while in IDLE/REQ/DONE is ignored.
- complete:
  - 1 in DONE.
  - 1 in IDLE when !mem_valid || mem_cancel.
  - 0 otherwise.
- Minimum latency: addr_ok in the issue cycle plus data_ok one cycle later gives complete 2 cycles after issue.
- Size encoding: types 0,1,5 -> 0; types 2,3,6 -> 1; types 4,7 -> 2.
- Store replication: sb -> {4{wdata[7:0]}}; sh -> {2{wdata[15:0]}}; sw -> wdata.
- Load extension in DONE:
  - Byte lane = rdata[8*addr[1:0] +: 8]; lb sign-extends, lbu zero-extends.
  - Half = addr[1] ? rdata[31:16] : rdata[15:0]; lh sign-extends, lhu zero-extends.
  - lw passes the word through.
  - For stores, and outside DONE, dmm_load_val = 0.
- Misaligned accesses are never issued: the MEM stage raises mem_cancel for them.
- A flush arriving after issue does not abort the bus transaction. The bridge completes it and the stage discards the result.
- Back-to-back: DONE+advance -> IDLE. The next request issues the following cycle.
- Reset mid-transaction abandons it; the bus slave shares the same reset.

Decomposition:
- Shared package holds:
  - LSTYPE_* constants (0..7)
  - SIZE_BYTE/HALF/WORD
  - FSM state encoding
- One sub-module, dmm_load_ext: combinational (type, addr[1:0], rdata) -> extended value. It is reused by the uncached path.

Test Plan:
- lw at 0x1000, addr_ok in issue cycle, data_ok next cycle with rdata 0xDEADBEEF -> data_size=2, complete=1 two cycles after issue, dmm_load_val=0xDEADBEEF.
- lb at 0x1003 with rdata 0x80123456 -> dmm_load_val=0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh at 0x2002 with wdata 0x0000ABCD, addr_ok withheld 3 cycles -> data_req held high 4 cycles, data_wdata=0xABCDABCD, data_size=1, ready=0 while in REQ.
- mem_valid with mem_cancel=1 in IDLE -> data_req never asserted, complete=1 same cycle.
- DONE with stage_advance low for 5 cycles -> dmm_load_val and complete held stable. Advance -> IDLE; next lhu at 0x3002 with rdata 0x9ABC1234 -> 0x00009ABC.
- Reset asserted while in WAIT -> state IDLE immediately, data_req=0, complete=1. A stray data_ok after reset is ignored.
